// File: rtl/vram_scanout_arbiter.sv
// Shares a single-port sync-read VRAM between 1 bpp scan-out and a CPU requester.
// Latency: video slot -> pixel 8k is 2 cycles; CPU read ack -> rvalid is 1 cycle.
// Backpressure: video slots always win; CPU req is held until o_cpu_ack, worst-case wait 1 cycle.
//
// Ports:
//   i_clk, i_rst_n         pixel clock, synchronous active-low reset
//   i_hpos, i_vpos         raster position from the sync generator
//   o_pixel                pixel for the current position, 0 outside the visible area
//   i_cpu_*/o_cpu_*        CPU request (held until ack), read return (rvalid pulse)
//   o_ram_*/i_ram_rdata    VRAM port, read data one cycle after the address
module vram_scanout_arbiter #(
   parameter int H_VISIBLE  = 640,
   parameter int H_TOTAL    = 800,
   parameter int V_VISIBLE  = 480,
   parameter int V_TOTAL    = 525,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [9:0]            i_hpos,
   input  logic [9:0]            i_vpos,
   output logic                  o_pixel,
   input  logic                  i_cpu_req,
   input  logic                  i_cpu_we,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
   output logic                  o_cpu_ack,
   output logic [DATA_WIDTH-1:0] o_cpu_rdata,
   output logic                  o_cpu_rvalid,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_we,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

   localparam logic [9:0] HVIS          = 10'(H_VISIBLE);
   localparam logic [9:0] VVIS          = 10'(V_VISIBLE);
   localparam logic [9:0] HPOS_LAST_MID = 10'(H_VISIBLE - 10);
   localparam logic [9:0] HPOS_K0       = 10'(H_TOTAL - 2);
   localparam logic [9:0] HPOS_LINE_END = 10'(H_TOTAL - 1);
   localparam logic [9:0] VPOS_PRE_LAST = 10'(V_VISIBLE - 2);
   localparam logic [9:0] VPOS_LAST     = 10'(V_TOTAL - 1);
   localparam logic [ADDR_WIDTH-1:0] VADDR_LAST = ADDR_WIDTH'(H_VISIBLE / 8 * V_VISIBLE - 1);
   localparam logic [ADDR_WIDTH-1:0] VADDR_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] r_vaddr;
   logic [DATA_WIDTH-1:0] r_load;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_vid_rd;
   logic                  r_cpu_rd;
   logic                  r_frame_ok;

   logic                  slot_mid;
   logic                  slot_k0;
   logic                  frame_start;
   logic                  vid_slot;
   logic                  load_now;
   logic [ADDR_WIDTH-1:0] vid_addr;
   logic [DATA_WIDTH-1:0] load_word;

   // Word k is fetched two pixels ahead of its first pixel; word 0 of a line
   // is fetched at the end of the previous line (line V_TOTAL-1 for line 0).
   always_comb begin
      slot_mid    = (i_hpos[2:0] == 3'd6) && (i_hpos <= HPOS_LAST_MID) && (i_vpos < VVIS);
      slot_k0     = (i_hpos == HPOS_K0) && ((i_vpos == VPOS_LAST) || (i_vpos <= VPOS_PRE_LAST));
      frame_start = (i_hpos == HPOS_K0) && (i_vpos == VPOS_LAST);
      vid_slot    = slot_mid || slot_k0;
      // The frame-start slot reads word 0 directly so the counter can reload in parallel.
      vid_addr    = frame_start ? '0 : r_vaddr;
      // Shift register reloads on the last pixel before each word boundary.
      load_now    = ((i_hpos[2:0] == 3'd7) && (i_hpos < HVIS)) || (i_hpos == HPOS_LINE_END);
      // The fetched word arrives in the same cycle it must be loaded, so bypass r_load.
      load_word   = r_vid_rd ? i_ram_rdata : r_load;
   end

   always_comb begin
      o_cpu_ack    = i_rst_n && i_cpu_req && !vid_slot;
      o_ram_addr   = vid_slot ? vid_addr : i_cpu_addr;
      o_ram_we     = o_cpu_ack && i_cpu_we;
      o_ram_wdata  = i_cpu_wdata;
      o_cpu_rdata  = i_ram_rdata;
      o_cpu_rvalid = r_cpu_rd;
      o_pixel      = r_shift[DATA_WIDTH-1] && (i_hpos < HVIS) && (i_vpos < VVIS);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vaddr    <= '0;
         r_load     <= '0;
         r_shift    <= '0;
         r_vid_rd   <= 1'b0;
         r_cpu_rd   <= 1'b0;
         r_frame_ok <= 1'b0;
      end else begin
         // Until a frame start has been seen the address counter is meaningless,
         // so fetched words are discarded and the screen stays dark.
         r_vid_rd <= vid_slot && (r_frame_ok || frame_start);
         r_cpu_rd <= o_cpu_ack && !i_cpu_we;

         if (frame_start) begin
            r_vaddr    <= VADDR_ONE;
            r_frame_ok <= 1'b1;
         end else if (vid_slot && r_frame_ok && (r_vaddr != VADDR_LAST)) begin
            r_vaddr <= r_vaddr + VADDR_ONE;
         end

         if (r_vid_rd)
            r_load <= i_ram_rdata;

         if (load_now)
            r_shift <= load_word;
         else
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Bench for vram_scanout_arbiter on a reduced raster (32x6 visible, 48x12 total).
// Latency: drives the raster counters and a 1-cycle sync-read VRAM model.
// Backpressure: CPU requests are held until acknowledged, as a bus bridge would.
module tb_vram_scanout_arbiter;

   localparam int HV = 32;
   localparam int HT = 48;
   localparam int VV = 6;
   localparam int VT = 12;
   localparam int WPL = HV / 8;
   localparam logic [7:0] SENT = 8'hFF;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] hpos, vpos;
   logic       o_pixel;
   logic       cpu_req, cpu_we;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       o_cpu_ack;
   logic [7:0] o_cpu_rdata;
   logic       o_cpu_rvalid;
   logic [7:0] o_ram_addr;
   logic       o_ram_we;
   logic [7:0] o_ram_wdata;
   logic [7:0] ram_rdata;

   logic [7:0] mem [256];
   logic       preload;

   int n_vec = 0, n_bad = 0;
   int pix_err, rv_cnt, stall_cnt, slot_err, we_slot, fetch_cnt, fetch_err, exp_fetch, rd_err;
   bit pix_en = 0, fetch_en = 0, blank = 1;
   logic       s_pixel, s_ack, s_rvalid, s_we;
   logic [7:0] s_rdata, s_ram_addr;
   logic [9:0] s_h, s_v;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   vram_scanout_arbiter #(
      .H_VISIBLE(HV), .H_TOTAL(HT), .V_VISIBLE(VV), .V_TOTAL(VT),
      .ADDR_WIDTH(8), .DATA_WIDTH(8)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .o_pixel(o_pixel),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata), .o_cpu_rvalid(o_cpu_rvalid),
      .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata),
      .i_ram_rdata(ram_rdata)
   );

   // Synchronous-read VRAM model.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 29 + 67);
      end else begin
         if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
         ram_rdata <= mem[o_ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (v=%0d h=%0d)", tag, got, exp, s_v, s_h);
      end
   endtask

   function automatic bit is_slot(input int h, input int v);
      return ((h % 8 == 6) && (h <= HV - 10) && (v < VV)) ||
             ((h == HT - 2) && ((v == VT - 1) || (v <= VV - 2)));
   endfunction

   // One pixel clock: sample at the falling edge, then advance the raster.
   task automatic cyc();
      logic [7:0] w;
      logic       exp_pix;
      @(negedge clk);
      s_h = hpos; s_v = vpos; s_pixel = o_pixel; s_ack = o_cpu_ack; s_rvalid = o_cpu_rvalid;
      s_rdata = o_cpu_rdata; s_ram_addr = o_ram_addr; s_we = o_ram_we;
      exp_pix = 1'b0;
      if (!blank && hpos < HV && vpos < VV) begin
         w = mem[int'(vpos) * WPL + int'(hpos) / 8];
         exp_pix = w[7 - int'(hpos) % 8];
      end
      if (pix_en && o_pixel !== exp_pix) pix_err++;
      if (o_cpu_rvalid === 1'b1) rv_cnt++;
      if (fetch_en && !cpu_req && o_ram_addr != SENT) begin
         if (o_ram_addr != 8'(exp_fetch)) fetch_err++;
         exp_fetch = (exp_fetch + 1) % (WPL * VV);
         fetch_cnt++;
      end
      if (cpu_req && rst_n) begin
         if (o_cpu_ack == is_slot(hpos, vpos)) slot_err++;
         if (!o_cpu_ack) stall_cnt++;
      end
      if (is_slot(hpos, vpos) && o_ram_we === 1'b1) we_slot++;
      @(posedge clk);
      #1;
      if (hpos == 10'(HT - 1)) begin
         hpos = '0;
         vpos = (vpos == 10'(VT - 1)) ? '0 : vpos + 10'd1;
      end else begin
         hpos = hpos + 10'd1;
      end
      if (hpos == 0 && vpos == 0) blank = 0;
   endtask

   task automatic run_to(input int v, input int h);
      int n = 0;
      while (!(vpos == 10'(v) && hpos == 10'(h)) && n < 2 * HT * VT) begin
         cyc();
         n++;
      end
      chk("run_to_pos", 32'({vpos, hpos}), 32'({10'(v), 10'(h)}));
   endtask

   initial begin
      int i, guard;
      logic [9:0] st_v, st_h;
      rst_n = 0; preload = 1; hpos = 10'd40; vpos = 10'(VT - 1);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05; cpu_wdata = 8'h00;
      st_v = '0; st_h = '0;

      // Reset: ack forced low, RAM address follows the CPU, state cleared.
      cyc(); preload = 0;
      chk("rst_ram_addr", s_ram_addr, 8'h05);
      chk("rst_ack", s_ack, 0);
      cyc();
      chk("rst_ack2", s_ack, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_pixel", s_pixel, 0);
      cyc();
      rst_n = 1; cpu_req = 0; cpu_addr = SENT;
      run_to(0, 0);

      // Two idle frames: image and fetch sequence.
      pix_en = 1;
      for (int f = 0; f < 2; f++) begin
         pix_err = 0; fetch_cnt = 0; fetch_err = 0; exp_fetch = 1; fetch_en = 1;
         repeat (HT * VT) cyc();
         fetch_en = 0;
         chk("idle_pix_err", pix_err, 0);
         chk("idle_fetch_cnt", fetch_cnt, 24);
         chk("idle_fetch_seq_err", fetch_err, 0);
      end

      // CPU read collides with a video slot.
      pix_err = 0; rv_cnt = 0;
      run_to(3, 14);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h34;
      cyc();
      chk("conf_ack_slot", s_ack, 0);
      chk("conf_vid_addr", s_ram_addr, 8'h0E);
      chk("conf_we_slot", s_we, 0);
      cyc();
      chk("conf_ack_next", s_ack, 1);
      chk("conf_cpu_addr", s_ram_addr, 8'h34);
      chk("conf_rvalid_early", s_rvalid, 0);
      cpu_req = 0; cpu_addr = SENT;
      cyc();
      chk("conf_rvalid", s_rvalid, 1);
      chk("conf_rdata", s_rdata, 8'h27);
      run_to(0, 0);
      chk("conf_pix_err", pix_err, 0);
      chk("conf_rv_cnt", rv_cnt, 1);

      // Back-to-back CPU stream in vblank, crossing the frame-start slot.
      run_to(9, 20);
      pix_err = 0; rv_cnt = 0; stall_cnt = 0; slot_err = 0; rd_err = 0;
      i = 0; guard = 0;
      while (i < 128 && guard < 300) begin
         cpu_req = 1; cpu_we = (i < 64);
         cpu_addr = 8'(8'h80 + i % 64); cpu_wdata = 8'((i % 64) * 5 + 17);
         cyc();
         guard++;
         if (s_rvalid) begin
            if (exp_q.size() == 0 || s_rdata !== exp_q[0]) rd_err++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (s_ack) begin
            if (!cpu_we) exp_q.push_back(cpu_wdata);
            i++;
         end else begin
            st_v = s_v; st_h = s_h;
         end
      end
      cpu_req = 0; cpu_addr = SENT;
      cyc();
      if (s_rvalid) begin
         if (exp_q.size() == 0 || s_rdata !== exp_q[0]) rd_err++;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      chk("stream_accepted", i, 128);
      chk("stream_stalls", stall_cnt, 1);
      chk("stream_stall_v", st_v, 11);
      chk("stream_stall_h", st_h, 46);
      chk("stream_rvalids", rv_cnt, 64);
      chk("stream_rdata_err", rd_err, 0);
      chk("stream_left", exp_q.size(), 0);
      chk("stream_slot_err", slot_err, 0);
      chk("stream_pix_err", pix_err, 0);

      // Write 0xFF to word 0 in vblank; it shows in the next frame.
      run_to(7, 0);
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h00; cpu_wdata = 8'hFF;
      guard = 0;
      do begin cyc(); guard++; end while (!s_ack && guard < 10);
      chk("wr_ack", s_ack, 1);
      cpu_req = 0; cpu_addr = SENT;
      run_to(0, 0);
      pix_err = 0;
      for (int x = 0; x < 9; x++) begin
         cyc();
         chk("wr_pix", s_pixel, (x < 8) ? 1 : 0);
      end
      run_to(0, 0);
      chk("wr_frame_pix_err", pix_err, 0);

      // Reset mid-line: dark and silent until the next frame.
      run_to(3, 20);
      pix_err = 0; rv_cnt = 0;
      rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      cyc();
      chk("mrst_ack1", s_ack, 0);
      chk("mrst_ram_addr", s_ram_addr, 8'h10);
      blank = 1;
      cyc();
      chk("mrst_ack2", s_ack, 0);
      chk("mrst_pixel", s_pixel, 0);
      cyc();
      chk("mrst_ack3", s_ack, 0);
      chk("mrst_rvalid", s_rvalid, 0);
      rst_n = 1; cpu_req = 0; cpu_addr = SENT;
      run_to(0, 0);
      chk("mrst_dark_pix_err", pix_err, 0);
      chk("mrst_rv_cnt", rv_cnt, 0);

      // Continuous CPU writes for a whole frame; image must resume intact.
      pix_err = 0; stall_cnt = 0; slot_err = 0; we_slot = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h90; cpu_wdata = 8'hAA;
      repeat (HT * VT) cyc();
      cpu_req = 0; cpu_addr = SENT;
      chk("bnd_stalls", stall_cnt, 24);
      chk("bnd_slot_err", slot_err, 0);
      chk("bnd_we_in_slot", we_slot, 0);
      chk("bnd_pix_err", pix_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
